// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {instr, pc} pairs; flush wins over push and pop.
module fetch_queue #(
    parameter int unsigned ADDR_W = fetch_pkg::ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [fetch_pkg::INSTR_W-1:0]  push_instr,
    input  logic [ADDR_W-1:0]              push_pc,
    input  logic                           pop,
    input  logic                           flush,
    output logic [1:0]                     count,
    output logic [fetch_pkg::INSTR_W-1:0]  head_instr,
    output logic [ADDR_W-1:0]              head_pc
);
    localparam int unsigned INSTR_W = fetch_pkg::INSTR_W;

    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic [ADDR_W-1:0]  pc_q    [2];
    logic [ADDR_W-1:0]  pc_d    [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                instr_d[wr_ptr_q] = push_instr;
                pc_d[wr_ptr_q]    = push_pc;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    // Entries are cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '{default: '0};
            pc_q     <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_instr = instr_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single outstanding imem request, redirect/drain handling,
// and a 2-entry buffer toward decode.
module instruction_fetch #(
    parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
    parameter int unsigned       PC_STEP  = fetch_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready
);
    import fetch_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [1:0]        q_count;
    logic              q_push, q_pop, q_flush;
    logic              in_flight;

    // Request is gated combinationally so a redirect or reset withdraws it at once.
    assign imem_req  = (state_q == FETCH) && (q_count < 2'd2) && !rst && !redirect_valid;
    assign imem_addr = pc_q;
    assign if_valid  = (q_count != 2'd0);
    assign in_flight = (state_q == WAIT) || (state_q == DRAIN);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        q_push   = 1'b0;
        q_pop    = if_valid && if_ready;
        q_flush  = 1'b0;

        case (state_q)
            FETCH: begin
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(PC_STEP);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    q_push  = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect overrides everything; a response still owed by memory must be drained.
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            q_flush = 1'b1;
            q_push  = 1'b0;
            q_pop   = 1'b0;
            if ((in_flight && !imem_rvalid) || ((state_q == FETCH) && imem_gnt)) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_instr (imem_rdata),
        .push_pc    (req_pc_q),
        .pop        (q_pop),
        .flush      (q_flush),
        .count      (q_count),
        .head_instr (if_instr),
        .head_pc    (if_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a queue-level model of the
// decode-visible stream and a behavioural instruction memory.
module tb_instruction_fetch;

    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: PCs of words decode should see, next fetch address, request in flight.
    logic [31:0] mq[$];
    logic [31:0] next_pc;
    bit          outstanding;
    int          epoch;
    int          out_epoch;
    bit          fresh;
    bit          armed;
    int          handshakes;

    // Memory: one pending response with a countdown.
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    int p_gnt   = 100;
    int min_lat = 1;
    int max_lat = 1;
    int p_ready = 100;
    int p_stray = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input bit do_rst, input bit do_redir, input logic [31:0] rpc);
        bit          rv_real;
        bit          rv_stray;
        bit          hs;
        bit          live;
        bit          exp_req;
        logic [31:0] resp_addr;

        rst            = do_rst;
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        if_ready       = ($urandom_range(99) < p_ready);
        rv_real        = mem_pend && (mem_cnt == 0);
        rv_stray       = !rv_real && !outstanding && !mem_pend && ($urandom_range(99) < p_stray);
        imem_rvalid    = rv_real || rv_stray;
        imem_rdata     = rv_real ? mem_word(mem_addr) : $urandom;
        resp_addr      = mem_addr;
        #1;
        imem_gnt = imem_req && ($urandom_range(99) < p_gnt);
        #3;

        if (armed) begin
            exp_req = !do_rst && !do_redir && !outstanding && (mq.size() < 2);
            chk("imem_req", imem_req, exp_req);
            chk("imem_addr", imem_addr, next_pc);
            chk("if_valid", if_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("if_pc", if_pc, mq[0]);
                chk("if_instr", if_instr, mem_word(mq[0]));
            end else if (fresh) begin
                chk("if_pc_reset", if_pc, 0);
                chk("if_instr_reset", if_instr, 0);
            end
        end

        hs = (mq.size() != 0) && if_ready;
        if (do_rst) begin
            mq.delete();
            outstanding = 0;
            mem_pend    = 0;
            next_pc     = RESET_PC;
            epoch++;
            fresh = 1;
            armed = 1;
        end else begin
            live = 0;
            if (rv_real) begin
                live        = (out_epoch == epoch) && !do_redir;
                mem_pend    = 0;
                outstanding = 0;
            end else if (mem_pend) begin
                mem_cnt--;
            end
            if (imem_gnt) begin
                outstanding = 1;
                out_epoch   = epoch;
                mem_pend    = 1;
                mem_addr    = imem_addr;
                mem_cnt     = $urandom_range(max_lat, min_lat) - 1;
                next_pc     = next_pc + PC_STEP;
            end
            if (do_redir) begin
                mq.delete();
                next_pc = rpc;
                epoch++;
            end else begin
                if (hs) begin
                    void'(mq.pop_front());
                    handshakes++;
                end
                if (live) begin
                    mq.push_back(resp_addr);
                    fresh = 0;
                end
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          found;
        int          r;
        logic [31:0] tgt;

        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cycle(1, 0, 0);

        // Zero-wait memory, decode always ready: one word per two cycles.
        repeat (10) cycle(0, 0, 0);
        handshakes = 0;
        repeat (40) cycle(0, 0, 0);
        chk("zero_wait_rate", handshakes, 20);

        // Backpressure fills the queue and stops requests.
        p_ready = 0;
        repeat (10) cycle(0, 0, 0);
        chk("bp_full_valid", if_valid, 1);
        p_ready = 100;
        repeat (10) cycle(0, 0, 0);

        // Redirect while a slow response is outstanding.
        min_lat = 3; max_lat = 3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (outstanding && mem_pend && mem_cnt > 0) begin found = 1; break; end
            cycle(0, 0, 0);
        end
        chk("reach_wait", found, 1);
        cycle(0, 1, 32'h0000_0100);
        repeat (20) cycle(0, 0, 0);

        // Redirect coinciding with a response and a pop.
        min_lat = 1; max_lat = 2; p_ready = 40;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (mem_pend && mem_cnt == 0 && mq.size() != 0) begin
                p_ready = 100;
                cycle(0, 1, 32'h0000_0200);
                found = 1;
                break;
            end
            cycle(0, 0, 0);
        end
        chk("coincide_found", found, 1);
        p_ready = 100;
        repeat (10) cycle(0, 0, 0);

        // PC wrap across the top of the address space.
        min_lat = 1; max_lat = 1;
        cycle(0, 1, 32'hFFFF_FFF8);
        repeat (12) cycle(0, 0, 0);

        // Reset with one word buffered and a request in flight, then a stale rvalid.
        p_ready = 0; min_lat = 3; max_lat = 3;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (mq.size() == 1 && outstanding) begin found = 1; break; end
            cycle(0, 0, 0);
        end
        chk("reach_wait_one_queued", found, 1);
        cycle(1, 0, 0);
        p_stray = 100;
        cycle(0, 0, 0);
        p_stray = 0; p_ready = 100; min_lat = 1; max_lat = 1;
        repeat (10) cycle(0, 0, 0);

        // Randomized mix of latency, grant, backpressure, redirects and resets.
        repeat (30) begin
            p_gnt   = $urandom_range(100, 30);
            min_lat = 1;
            max_lat = $urandom_range(4, 1);
            p_ready = $urandom_range(100, 0);
            p_stray = $urandom_range(20, 0);
            repeat (100) begin
                r = $urandom_range(999);
                case ($urandom_range(2))
                    0: begin tgt = $urandom; tgt[1:0] = 2'b00; end
                    1: tgt = 32'h0000_0100;
                    default: tgt = 32'hFFFF_FFF8;
                endcase
                if (r < 4)       cycle(1, 0, 0);
                else if (r < 60) cycle(0, 1, tgt);
                else             cycle(0, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage that feeds `instruction_decoder`. It holds the program counter and issues single-word requests to instruction memory, allowing one request in flight at a time. Returned words are buffered with their PC in a 2-entry queue and presented to decode through a valid/ready handshake. A redirect input from the branch/execute stage loads a new PC, flushes buffered words and discards any response still in flight.

## Interface
Parameters:
- `ADDR_W`, 32, PC / memory address width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `PC_STEP`, 4, increment applied after each granted request (byte-addressed 32-bit words).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch address; equals current PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response word valid.
- `imem_rdata`  in  32  response word.
- `redirect_valid`  in  1  load new PC and flush.
- `redirect_pc`  in  ADDR_W  new PC.
- `if_valid`  out  1  instruction available to decode.
- `if_instr`  out  32  instruction word; goes to the decoder's `instruction` input.
- `if_pc`  out  ADDR_W  address of `if_instr`.
- `if_ready`  in  1  decode accepts the word.

## Operation
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: one granted request outstanding.
  - DRAIN: an outstanding response is to be discarded.
- `imem_req` is asserted only in FETCH, only when queue count < 2 (registered count), and never while `rst` or `redirect_valid` is high.
- Request stability: `imem_addr` stays stable while `imem_req` is high and no grant has arrived. A redirect may withdraw or retarget the request.
- FETCH with `imem_req && imem_gnt`: latch `req_pc` = PC, PC <= PC + PC_STEP (modulo 2^ADDR_W, wraps silently), go to WAIT.
- WAIT with `imem_rvalid`: push {`imem_rdata`, `req_pc`} into the queue, go to FETCH.
- DRAIN with `imem_rvalid`: drop the word, go to FETCH.
- `imem_rvalid` outside WAIT/DRAIN is ignored.
- Queue outputs: `if_valid` = count != 0; `if_instr`/`if_pc` = head entry. Pop on `if_valid && if_ready`. Push and pop in the same cycle are both allowed.
- `redirect_valid` (highest priority after `rst`):
  - PC <= `redirect_pc`; queue cleared, so `if_valid` = 0 next cycle.
  - Next state DRAIN if in WAIT without `imem_rvalid`, in DRAIN without `imem_rvalid`, or in FETCH with `imem_gnt`.
  - Otherwise next state FETCH.
  - A pop or push in the same cycle is overridden.
- Reset: PC = RESET_PC, state FETCH, queue empty. Outputs during and after reset: `imem_req` 0, `imem_addr` RESET_PC, `if_valid` 0, `if_instr` 0, `if_pc` 0.
- Reset mid-transaction abandons the in-flight request. The memory is reset by the same `rst`.

## Timing
- `imem_rvalid` arrives no earlier than the cycle after `imem_gnt`.
- First `imem_req` is in the first cycle after `rst` falls.
- Zero-wait memory (gnt same cycle as req, rvalid next cycle): one word every 2 cycles.
- Latency: `imem_rvalid` at cycle N gives `if_valid` at N+1.
- `redirect_valid` at cycle N:
  - `if_valid` is 0 at N+1.
  - Earliest request to `redirect_pc` is at N+1 if nothing is outstanding. Otherwise it follows the discarded response.
- Backpressure: with `if_ready` low the queue fills to 2 and requests stop. A pop at cycle N re-enables `imem_req` at N+1.

## Structure
- Package `fetch_pkg`: `ADDR_W`, `PC_STEP`, `RESET_PC` defaults, state enum `fetch_state_t` {FETCH, WAIT, DRAIN}.
- Sub-module `fetch_queue`: 2-entry FIFO of {instr[31:0], pc[ADDR_W-1:0]} with push, pop, flush, count, and head outputs. Flush has priority over push and pop.
- Top level holds the PC, `req_pc`, FSM and request logic.

## Test plan
- Reset then zero-wait memory returning addr-tagged words, `if_ready`=1 → `imem_addr` sequence 0,4,8,…; `if_instr`/`if_pc` pairs in order; one word per 2 cycles.
- `if_ready`=0 for 10 cycles → exactly 2 words buffered, `imem_req` low. Raise `if_ready` → words at PC 0,4 delivered, fetch resumes at 8.
- Redirect to 0x100 while in WAIT (rvalid delayed 3 cycles) → late word discarded, never seen on `if_*`. Next request at 0x100 and `if_pc`=0x100 is the first word out.
- Redirect in the same cycle as `imem_rvalid` and a pop → queue empty next cycle, no DRAIN, request to the redirect PC the following cycle.
- PC = 0xFFFF_FFFC granted → next `imem_addr` = 0x0000_0000.
- Assert `rst` while in WAIT with 1 queued word → next cycle `if_valid`=0, `imem_req`=0. A stale `imem_rvalid` after reset is ignored. Fetch restarts at RESET_PC.
